// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the decoder.
// Holds opcodes, class codes, error codes and the func3 legality table.
package rv_isa_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_IMM    = 3'd2,
        CLS_JALR   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_BRANCH = 3'd6,
        CLS_LUI    = 3'd7
    } instr_class_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_FUNC3 = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_t;

    function automatic logic [6:0] class_opcode(input instr_class_t cls);
        case (cls)
            CLS_R:      class_opcode = OP_R;
            CLS_LOAD:   class_opcode = OP_LOAD;
            CLS_IMM:    class_opcode = OP_IMM;
            CLS_JALR:   class_opcode = OP_JALR;
            CLS_STORE:  class_opcode = OP_STORE;
            CLS_JAL:    class_opcode = OP_JAL;
            CLS_BRANCH: class_opcode = OP_BRANCH;
            default:    class_opcode = OP_LUI;
        endcase
    endfunction

    // JAL and LUI carry no func3, so any value is accepted for them.
    function automatic logic func3_legal(input instr_class_t cls, input logic [2:0] f3);
        case (cls)
            CLS_R:             func3_legal = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b011) ||
                                             (f3 == 3'b110) || (f3 == 3'b111);
            CLS_LOAD, CLS_STORE: func3_legal = (f3 == 3'b010);
            CLS_IMM:           func3_legal = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b011) ||
                                             (f3 == 3'b100) || (f3 == 3'b110);
            CLS_JALR:          func3_legal = (f3 == 3'b000);
            CLS_BRANCH:        func3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) ||
                                             (f3 == 3'b101);
            default:           func3_legal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; push when full and pop when empty are ignored.
// Head entry is visible on rdata whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level RV32I requests into instruction words and streams them to imem.
// Request side: valid/ready, a transfer happens on a rising edge where both are high; write side likewise with imem_we/imem_ready, and imem_we/addr/wdata stay stable until imem_ready.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int              FIFO_DEPTH = 4,
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_func3,
    input  logic [6:0]        in_func7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_count,
    output logic [1:0]        dbg_state
);

    enc_state_t   state, state_next;
    instr_class_t cls;
    err_code_t    code;
    logic signed [31:0] simm;
    logic [6:0]   op;
    logic [31:0]  enc_word;
    logic         range_bad, align_bad;
    logic         accept, push, wr_fire;
    logic         fifo_full, fifo_empty;
    logic [31:0]  fifo_rdata;

    always_comb begin
        cls       = instr_class_t'(in_class);
        simm      = signed'(in_imm);
        op        = class_opcode(cls);
        enc_word  = '0;
        range_bad = 1'b0;
        align_bad = 1'b0;
        case (cls)
            CLS_R: enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, op};
            CLS_LOAD, CLS_IMM, CLS_JALR: begin
                enc_word  = {in_imm[11:0], in_rs1, in_func3, in_rd, op};
                range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            CLS_STORE: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], op};
                range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            CLS_BRANCH: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                             in_imm[4:1], in_imm[11], op};
                range_bad = (simm < -32'sd4096) || (simm > 32'sd4094);
                align_bad = in_imm[0];
            end
            CLS_JAL: begin
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
                range_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574);
                align_bad = in_imm[0];
            end
            default: begin
                enc_word  = {in_imm[31:12], in_rd, op};
                align_bad = (in_imm[11:0] != 12'd0);
            end
        endcase
    end

    // Fault precedence: func3 beats alignment beats range.
    always_comb begin
        if (!func3_legal(cls, in_func3)) code = ERR_FUNC3;
        else if (align_bad)              code = ERR_ALIGN;
        else if (range_bad)              code = ERR_RANGE;
        else                             code = ERR_NONE;
    end

    assign accept  = in_valid && in_ready;
    assign push    = accept && (code == ERR_NONE);
    assign wr_fire = imem_we && imem_ready;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc_word),
        .pop   (wr_fire),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_we    = !fifo_empty;
    assign imem_wdata = fifo_empty ? 32'd0 : fifo_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)             state_next = ST_RUN;
            ST_RUN:   if (accept && in_last) state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)        state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        in_ready  = (state == ST_RUN) && !fifo_full;
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            done       <= 1'b0;
        end else begin
            err      <= accept && (code != ERR_NONE);
            err_code <= accept ? code : ERR_NONE;
            done     <= (state == ST_DRAIN) && (state_next == ST_IDLE);
            if ((state == ST_IDLE) && start) begin
                imem_addr  <= BASE_ADDR;
                word_count <= '0;
            end else if (wr_fire) begin
                imem_addr <= imem_addr + ADDR_W'(4);
                if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            end
        end
    end

endmodule
